// File: rtl/mvp_dot_accel_avalon_slave_if.sv
// Avalon-MM slave bus bundle for the dot-product accelerator register file.
interface mvp_dot_accel_avalon_slave_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/mvp_dot_accel_avalon_slave.sv
// Memory-mapped dot-product accelerator: loads two LANES-element vectors and
// accumulates their element-wise products, one lane per cycle.
module mvp_dot_accel_avalon_slave #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input logic                         clock,
  input logic                         resetn,
  mvp_dot_accel_avalon_slave_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(LANES);
  localparam int unsigned SW    = 34;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_A      = 3'd1;
  localparam logic [2:0] ADDR_B      = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ELEM_W-1:0] a_mem [LANES];
  logic [ELEM_W-1:0] b_mem [LANES];
  logic [PTR_W-1:0]  ptr_a, ptr_b, lane;
  logic [ACC_W-1:0]  acc;
  logic              done_q, ovf_q, sgn_q;

  logic              wr_go, rd_go, start_c, busy, last_lane, add_ovf;
  logic signed [SW-1:0] a_s, b_s, prod_s, acc_s, sum_s;
  logic [31:0]       status_c, result_c, rd_mux_c;
  logic              unused_wdata;

  // Register writes stall while an operation is in flight; other traffic never does.
  assign bus.waitrequest = resetn && bus.write && (bus.address <= ADDR_B) && (state_q != S_IDLE);
  assign wr_go     = bus.write && !bus.waitrequest;
  assign rd_go     = bus.read && !bus.write;
  assign start_c   = wr_go && (bus.address == ADDR_CTRL) && bus.writedata[0];
  assign busy      = (state_q == S_RUN);
  assign last_lane = (lane == PTR_W'(LANES - 1));
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c) state_d = S_RUN;
      S_RUN:   if (last_lane) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Wide signed datapath; overflow means the sum does not survive a round trip through ACC_W bits.
  always_comb begin
    a_s     = {{(SW-ELEM_W){sgn_q & a_mem[lane][ELEM_W-1]}}, a_mem[lane]};
    b_s     = {{(SW-ELEM_W){sgn_q & b_mem[lane][ELEM_W-1]}}, b_mem[lane]};
    prod_s  = a_s * b_s;
    acc_s   = {{(SW-ACC_W){sgn_q & acc[ACC_W-1]}}, acc};
    sum_s   = acc_s + prod_s;
    add_ovf = (sum_s != {{(SW-ACC_W){sgn_q & sum_s[ACC_W-1]}}, sum_s[ACC_W-1:0]});
  end

  always_comb begin
    result_c = 32'({{32{sgn_q & acc[ACC_W-1]}}, acc});
    status_c = {15'd0, 5'(ptr_b), 3'd0, 5'(ptr_a), 1'b0, ovf_q, done_q, busy};
    rd_mux_c = '0;
    case (bus.address)
      ADDR_STATUS: rd_mux_c = status_c;
      ADDR_RESULT: rd_mux_c = result_c;
      default:     rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q           <= S_IDLE;
      a_mem             <= '{default: '0};
      b_mem             <= '{default: '0};
      ptr_a             <= '0;
      ptr_b             <= '0;
      lane              <= '0;
      acc               <= '0;
      done_q            <= 1'b0;
      ovf_q             <= 1'b0;
      sgn_q             <= 1'b0;
      bus.readdata      <= '0;
      bus.readdatavalid <= 1'b0;
    end else begin
      state_q           <= state_d;
      bus.readdatavalid <= rd_go;
      bus.readdata      <= rd_go ? rd_mux_c : 32'd0;

      if (wr_go) begin
        case (bus.address)
          ADDR_CTRL: begin
            if (bus.writedata[3]) begin
              ptr_a <= '0;
              ptr_b <= '0;
            end
            if (bus.writedata[0]) begin
              sgn_q  <= bus.writedata[2];
              done_q <= 1'b0;
              ovf_q  <= 1'b0;
              ptr_a  <= '0;
              ptr_b  <= '0;
              lane   <= '0;
              if (!bus.writedata[1]) acc <= '0;
            end
          end
          ADDR_A: begin
            a_mem[ptr_a] <= bus.writedata[ELEM_W-1:0];
            ptr_a        <= (ptr_a == PTR_W'(LANES - 1)) ? '0 : ptr_a + 1'b1;
          end
          ADDR_B: begin
            b_mem[ptr_b] <= bus.writedata[ELEM_W-1:0];
            ptr_b        <= (ptr_b == PTR_W'(LANES - 1)) ? '0 : ptr_b + 1'b1;
          end
          default: ;
        endcase
      end

      if (busy) begin
        acc  <= sum_s[ACC_W-1:0];
        lane <= last_lane ? '0 : lane + 1'b1;
        if (add_ovf) ovf_q <= 1'b1;
        if (last_lane) done_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mvp_dot_accel_avalon_slave.sv
// Scoreboard bench: directed register-map scenarios plus randomized dot products
// checked against an arithmetic reference model on two accumulator widths.
module tb_mvp_dot_accel_avalon_slave;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned ACC_W0 = 32;
  localparam int unsigned ACC_W1 = 16;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_ADATA  = 3'd1;
  localparam logic [2:0] A_BDATA  = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_RESULT = 3'd4;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  logic clock = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t q [2][$];

  // reference model state
  logic [ELEM_W-1:0] ma [2][LANES];
  logic [ELEM_W-1:0] mb [2][LANES];
  int     pa [2];
  int     pb [2];
  longint macc [2];
  bit     msgn [2];
  bit     movf [2];
  bit     mdone [2];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mvp_dot_accel_avalon_slave_if bus0 ();
  mvp_dot_accel_avalon_slave_if bus1 ();

  mvp_dot_accel_avalon_slave #(.LANES(LANES), .ELEM_W(ELEM_W), .ACC_W(ACC_W0)) dut0 (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus0)
  );

  mvp_dot_accel_avalon_slave #(.LANES(LANES), .ELEM_W(ELEM_W), .ACC_W(ACC_W1)) dut1 (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus1)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int accw(int w);
    return (w == 0) ? ACC_W0 : ACC_W1;
  endfunction

  function automatic longint elem_val(logic [ELEM_W-1:0] e, bit s);
    if (s && e[ELEM_W-1]) return longint'(e) - (longint'(1) <<< ELEM_W);
    return longint'(e);
  endfunction

  function automatic longint acc_val(int w, longint bits, bit s);
    int aw = accw(w);
    if (s && bits[aw-1]) return bits - (longint'(1) <<< aw);
    return bits;
  endfunction

  function automatic logic [31:0] m_result(int w);
    longint v = acc_val(w, macc[w], msgn[w]);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_status(int w, bit busy);
    logic [31:0] s = '0;
    s[0]     = busy;
    s[1]     = mdone[w];
    s[2]     = movf[w];
    s[8:4]   = 5'(pa[w]);
    s[16:12] = 5'(pb[w]);
    return s;
  endfunction

  task automatic m_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < LANES; i++) begin
        ma[w][i] = '0;
        mb[w][i] = '0;
      end
      pa[w] = 0; pb[w] = 0; macc[w] = 0;
      msgn[w] = 0; movf[w] = 0; mdone[w] = 0;
    end
  endtask

  task automatic m_ctrl(int w, logic [31:0] d);
    int aw = accw(w);
    longint lo, hi, t;
    if (d[3]) begin pa[w] = 0; pb[w] = 0; end
    if (d[0]) begin
      msgn[w] = d[2];
      if (!d[1]) macc[w] = 0;
      movf[w] = 0; pa[w] = 0; pb[w] = 0;
      lo = msgn[w] ? -(longint'(1) <<< (aw - 1)) : 0;
      hi = msgn[w] ? (longint'(1) <<< (aw - 1)) - 1 : (longint'(1) <<< aw) - 1;
      for (int i = 0; i < LANES; i++) begin
        t = acc_val(w, macc[w], msgn[w]) + elem_val(ma[w][i], msgn[w]) * elem_val(mb[w][i], msgn[w]);
        if (t < lo || t > hi) movf[w] = 1;
        macc[w] = t & ((longint'(1) <<< aw) - 1);
      end
      mdone[w] = 1;
    end
  endtask

  task automatic m_write(int w, logic [2:0] a, logic [31:0] d);
    case (a)
      A_CTRL: m_ctrl(w, d);
      A_ADATA: begin ma[w][pa[w]] = d[ELEM_W-1:0]; pa[w] = (pa[w] + 1) % LANES; end
      A_BDATA: begin mb[w][pb[w]] = d[ELEM_W-1:0]; pb[w] = (pb[w] + 1) % LANES; end
      default: ;
    endcase
  endtask

  // ---------------- bus drivers ----------------
  task automatic drive(int w, logic r, logic wr, logic [2:0] a, logic [31:0] d);
    if (w == 0) begin
      bus0.read = r; bus0.write = wr; bus0.address = a; bus0.writedata = d;
    end else begin
      bus1.read = r; bus1.write = wr; bus1.address = a; bus1.writedata = d;
    end
  endtask

  function automatic logic get_wait(int w);
    return (w == 0) ? bus0.waitrequest : bus1.waitrequest;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic mwr(int w, logic [2:0] a, logic [31:0] d, output int stalls);
    bit accepted = 0;
    stalls = 0;
    drive(w, 1'b0, 1'b1, a, d);
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (!get_wait(w)) begin accepted = 1; break; end
      stalls++;
    end
    if (accepted) begin
      @(posedge clock);
      #1;
      m_write(w, a, d);
    end else begin
      total++; bad++;
      $display("FAIL write_timeout inst=%0d addr=%0d actual=stalled expected=accepted", w, a);
      tick(1);
    end
    drive(w, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(int w, logic [2:0] a, logic [31:0] expv, string name);
    exp_t e;
    e.data = expv; e.cyc = cyc + 1; e.name = name;
    q[w].push_back(e);
    drive(w, 1'b1, 1'b0, a, 32'd0);
    tick(1);
    drive(w, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic load(int w, logic [LANES*ELEM_W-1:0] av, logic [LANES*ELEM_W-1:0] bv);
    int st;
    for (int i = 0; i < LANES; i++) mwr(w, A_ADATA, 32'(av[i*ELEM_W +: ELEM_W]), st);
    for (int i = 0; i < LANES; i++) mwr(w, A_BDATA, 32'(bv[i*ELEM_W +: ELEM_W]), st);
  endtask

  task automatic run_op(int w, logic [31:0] ctrl);
    int st;
    mwr(w, A_CTRL, ctrl, st);
    tick(LANES + 1);
  endtask

  // ---------------- monitor ----------------
  task automatic mon(int w, logic v, logic [31:0] d);
    exp_t e;
    if (v === 1'b1) begin
      if (q[w].size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_readdatavalid inst=%0d actual=1 expected=0", w);
      end else begin
        e = q[w].pop_front();
        check(e.name, d, e.data);
        check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("readdata_zero_when_invalid", d, 32'd0);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      mon(0, bus0.readdatavalid, bus0.readdata);
      mon(1, bus1.readdatavalid, bus1.readdata);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    int w;
    logic [31:0] d;
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
    m_reset();
    resetn = 1'b0;
    @(posedge clock);
    #1 mon_en = 1'b1;
    tick(2);
    resetn = 1'b1;

    rd(0, A_STATUS, 32'd0, "reset_status");
    rd(0, A_RESULT, 32'd0, "reset_result");
    rd(1, A_STATUS, 32'd0, "reset_status_w16");

    // basic unsigned dot product with busy/partial observation
    load(0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    rd(0, A_STATUS, 32'd0, "ptr_wrap_status");
    mwr(0, A_CTRL, 32'h1, st);
    rd(0, A_STATUS, 32'h1, "busy_first_cycle");
    rd(0, A_RESULT, 32'd5, "partial_one_lane");
    rd(0, A_RESULT, 32'd17, "partial_two_lanes");
    rd(0, A_STATUS, 32'h1, "busy_last_cycle");
    rd(0, A_STATUS, 32'h2, "done_status");
    rd(0, A_RESULT, 32'd70, "result_70");

    run_op(0, 32'h3);
    rd(0, A_RESULT, 32'd140, "accumulate_140");
    rd(0, A_STATUS, 32'h2, "accumulate_status");

    // data write one idle cycle after START is held off until the op retires
    mwr(0, A_CTRL, 32'h1, st);
    tick(1);
    mwr(0, A_ADATA, 32'd9, st);
    check("stall_cycles", 32'(st), 32'(LANES));
    rd(0, A_RESULT, 32'd70, "result_after_stall");
    rd(0, A_STATUS, 32'h12, "ptr_a_after_stall");

    // simultaneous read and write: write wins, no readdatavalid
    drive(0, 1'b1, 1'b1, A_ADATA, 32'h33);
    tick(1);
    drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
    m_write(0, A_ADATA, 32'h33);
    rd(0, A_STATUS, 32'h22, "rw_collision_status");

    mwr(0, A_CTRL, 32'h8, st);
    rd(0, A_STATUS, 32'h2, "ptr_rst_keeps_done");

    // signed vs unsigned interpretation of 0xFF
    load(0, {8'd0, 8'd0, 8'd2, 8'hFF}, {8'd0, 8'd0, 8'd3, 8'd3});
    run_op(0, 32'h5);
    rd(0, A_RESULT, 32'd3, "signed_result");
    run_op(0, 32'h1);
    rd(0, A_RESULT, 32'd771, "unsigned_result");

    // 16-bit accumulator overflow
    load(1, {4{8'hFF}}, {4{8'hFF}});
    run_op(1, 32'h1);
    rd(1, A_RESULT, 32'd63492, "w16_wrap_result");
    rd(1, A_STATUS, 32'h6, "w16_overflow_status");
    mwr(1, A_CTRL, 32'h1, st);
    rd(1, A_STATUS, 32'h1, "start_clears_overflow");
    mwr(1, 3'd6, 32'hFFFF_FFFF, st);
    check("unmapped_write_no_stall", 32'(st), 32'd0);
    rd(1, 3'd7, 32'd0, "unmapped_read_zero");
    tick(2);
    rd(1, A_RESULT, 32'd63492, "w16_rerun_result");
    for (int i = 0; i < LANES; i++) mwr(1, A_BDATA, 32'd0, st);
    run_op(1, 32'h1);
    rd(1, A_RESULT, 32'd0, "w16_zero_result");
    rd(1, A_STATUS, 32'h2, "w16_overflow_cleared");

    // reset in the middle of a run aborts it
    mwr(0, A_CTRL, 32'h1, st);
    tick(2);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    m_reset();
    rd(0, A_STATUS, 32'd0, "abort_status");
    rd(0, A_RESULT, 32'd0, "abort_result");
    tick(LANES + 2);
    rd(0, A_STATUS, 32'd0, "abort_no_done");

    // randomized operations against the reference model
    for (int t = 0; t < 30; t++) begin
      w = int'($urandom_range(0, 1));
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) mwr(w, A_ADATA, $urandom(), st);
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) mwr(w, A_BDATA, $urandom(), st);
      if ($urandom_range(0, 3) == 0) mwr(w, A_CTRL, $urandom() & 32'hFFFF_FFFE, st);
      rd(w, A_STATUS, m_status(w, 1'b0), "rand_pre_status");
      d = ($urandom() & 32'hFFFF_FFF0) | 32'(($urandom_range(0, 7) << 1) | 1);
      run_op(w, d);
      rd(w, A_STATUS, m_status(w, 1'b0), "rand_status");
      rd(w, A_RESULT, m_result(w), "rand_result");
    end

    tick(3);
    check("pending_reads_inst0", 32'(q[0].size()), 32'd0);
    check("pending_reads_inst1", 32'(q[1].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mvp_dot_accel_avalon_slave.md
MVP_DOT_ACCEL_AVALON_SLAVE -- requirements
Module: mvp_dot_accel_avalon_slave

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- LANES, 4, vector length (2..16).
- ELEM_W, 8, element width in bits (2..16).
- ACC_W, 32, accumulator/result width; must satisfy 2*ELEM_W <= ACC_W <= 32.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, clock.
- resetn, in, 1, reset, synchronous, active-low.
- address, in, 3, word register index.
- read, in, 1, Avalon read strobe.
- write, in, 1, Avalon write strobe.
- writedata, in, 32, write data.
- readdata, out, 32, read data.
- readdatavalid, out, 1, readdata qualifier.
- waitrequest, out, 1, stall for the current write.

REQ-003 Register map SHALL be:
- 0 CTRL (write-only): bit0 START, bit1 ACC_EN, bit2 SIGNED, bit3 PTR_RST.
- 1 A_DATA (write-only).
- 2 B_DATA (write-only).
- 3 STATUS (read-only): bit0 busy, bit1 done, bit2 overflow, bits[8:4] ptr_a, bits[16:12] ptr_b.
- 4 RESULT (read-only).
- All other addresses read as 0, and writes to them are ignored.

Function
REQ-004 A write to A_DATA SHALL store writedata[ELEM_W-1:0] into A[ptr_a], then advance ptr_a by 1, wrapping from LANES-1 to 0; B_DATA/B/ptr_b SHALL behave identically.
REQ-005 A CTRL write with PTR_RST=1 SHALL zero ptr_a and ptr_b, applied before any START in the same write.
REQ-006 FSM states SHALL be IDLE, RUN and DONE, with transitions:
- IDLE->RUN on a CTRL write with START=1.
- RUN->DONE after exactly LANES cycles.
- DONE->IDLE on the next cycle.
REQ-007 START SHALL latch SIGNED and ACC_EN, clear overflow and done, and zero ptr_a/ptr_b. If ACC_EN=0 the accumulator SHALL be cleared to 0; if ACC_EN=1 it SHALL retain the prior RESULT.
REQ-008 In RUN cycle i (0..LANES-1) the accumulator SHALL add A[i]*B[i]:
- Operands are zero-extended when SIGNED=0 and sign-extended when SIGNED=1.
- The sum is truncated to ACC_W bits.
REQ-009 overflow SHALL be set and held if any addition's true value is unrepresentable in ACC_W bits, using unsigned range for SIGNED=0 and two's complement range for SIGNED=1.
REQ-010 The latency from the START write accept cycle T SHALL be:
- busy=1 from T+1 through T+LANES.
- RESULT is final and done=1 at T+LANES+1.
- done stays 1 until the next START.
REQ-011 RESULT SHALL be the accumulator, zero-extended to 32 bits when SIGNED=0 and sign-extended when SIGNED=1.
REQ-012 waitrequest SHALL be asserted combinationally for writes to CTRL, A_DATA or B_DATA while the FSM is not IDLE, and the write SHALL complete on the first IDLE cycle; writes elsewhere and all reads SHALL never stall.
REQ-013 Reads SHALL have fixed latency 1: readdatavalid=1 and readdata valid in the cycle after read is sampled; readdata SHALL be 0 whenever readdatavalid=0.
REQ-014 A RESULT read while busy SHALL return the current partial accumulator.
REQ-015 If read and write are asserted in the same cycle, the write SHALL be performed, the read ignored, and no readdatavalid issued.
REQ-016 A CTRL write with START=0 SHALL only apply PTR_RST and SHALL NOT alter done/overflow.

Reset
REQ-017 While resetn=0 at a clock edge, the block SHALL reset as follows:
- FSM goes to IDLE.
- Accumulator, A, B, ptr_a, ptr_b, done, overflow, busy and latched modes go to 0.
- readdata=0, readdatavalid=0, waitrequest=0.
REQ-018 Reset asserted mid-RUN SHALL abort the operation, and the first post-reset STATUS read SHALL return 0.

Verification (LANES=4, ELEM_W=8, ACC_W=32 unless stated)
REQ-019 Reset, then read STATUS and RESULT -> both reads return 0, with readdatavalid one cycle after each read.
REQ-020 A={1,2,3,4}, B={5,6,7,8}, CTRL=0x1 -> busy for 4 cycles; at T+5 done=1 and RESULT=70. Then CTRL=0x3 (ACC_EN) with the same data -> RESULT=140.
REQ-021 A={0xFF,2,0,0}, B={3,3,0,0}:
- CTRL=0x5 (signed) -> RESULT=3.
- CTRL=0x1 (unsigned) -> RESULT=771.
REQ-022 An A_DATA write issued one cycle after START -> waitrequest=1 for 4 cycles, then accepted; the RESULT of the running op is unchanged and ptr_a=1 after.
REQ-023 ACC_W=16, A=B={255,255,255,255}, unsigned START -> RESULT=63492, overflow=1; the next START clears overflow.
REQ-024 resetn pulsed low at RUN cycle 2 -> STATUS=0, RESULT=0, ptr_a=ptr_b=0, and no done pulse.
